video_in_axis_framer: RTL and testbench



---
 rtl/video_axis_pkg.sv | 24 ++
 rtl/axis_sync_fifo.sv | 50 +++++
 rtl/video_in_axis_framer.sv | 189 ++++++++++++++++++
 tb/tb_video_in_axis_framer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_axis_pkg.sv
// Shared constants and types for the video-in to AXI4-Stream framer.
package video_axis_pkg;

    localparam int unsigned DefaultImgWidth  = 640;
    localparam int unsigned DefaultImgHeight = 480;
    localparam int unsigned DefaultFifoDepth = 16;
    localparam int unsigned DefaultDataWidth = 32;

    // Framer FSM encoding
    typedef logic [1:0] state_t;
    localparam state_t StIdle   = 2'd0;
    localparam state_t StArmed  = 2'd1;
    localparam state_t StActive = 2'd2;
    localparam state_t StDrop   = 2'd3;

    // Sideband bits stored alongside each pixel in the FIFO word {tuser, tlast, data}
    typedef struct packed {
        logic tuser;
        logic tlast;
    } pix_tag_t;

    localparam int unsigned PixTagWidth = 2;

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. Pointers carry an extra MSB so
// full and empty are distinguished without a separate counter.
module axis_sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 34
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push;
    logic             pop;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    // Full is judged before any same-cycle pop, so a push into a full FIFO is refused
    assign push  = wr_en && !full;
    assign pop   = rd_en && !empty;
    // Head word is presented directly; forced to zero when nothing is buffered
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update; reset empties the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PtrOne;
            if (pop)  rd_ptr <= rd_ptr + PtrOne;
        end
    end

    // Storage array write
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/video_in_axis_framer.sv
// Packs a DE/VSYNC/pixel video interface into AXI4-Stream with TUSER on the
// first pixel of a frame and TLAST on the last pixel of each line.
module video_in_axis_framer
    import video_axis_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = DefaultImgWidth,
    parameter int unsigned IMG_HEIGHT = DefaultImgHeight,
    parameter int unsigned FIFO_DEPTH = DefaultFifoDepth,
    parameter int unsigned DATA_WIDTH = DefaultDataWidth
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    enable,
    input  logic                    err_clr,
    input  logic                    vid_vsync,
    input  logic                    vid_de,
    input  logic [DATA_WIDTH-1:0]   vid_data,
    output logic                    OUTPUT_STREAM_TVALID,
    input  logic                    OUTPUT_STREAM_TREADY,
    output logic [DATA_WIDTH-1:0]   OUTPUT_STREAM_TDATA,
    output logic [DATA_WIDTH/8-1:0] OUTPUT_STREAM_TKEEP,
    output logic [DATA_WIDTH/8-1:0] OUTPUT_STREAM_TSTRB,
    output logic                    OUTPUT_STREAM_TUSER,
    output logic                    OUTPUT_STREAM_TLAST,
    output logic                    OUTPUT_STREAM_TID,
    output logic                    OUTPUT_STREAM_TDEST,
    output logic                    overflow,
    output logic                    line_err,
    output logic [15:0]             frame_count,
    output logic                    busy
);

    localparam int unsigned CW        = $clog2(IMG_WIDTH + 1);
    localparam int unsigned RW        = $clog2(IMG_HEIGHT + 1);
    localparam int unsigned WordWidth = DATA_WIDTH + PixTagWidth;
    localparam logic [CW-1:0] LastCol = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] LastRow = RW'(IMG_HEIGHT - 1);

    state_t          state_q, state_d;
    logic            vsync_q, de_q;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic            sof_q, sof_d;
    logic            overflow_q, overflow_d;
    logic            line_err_q, line_err_d;
    logic [15:0]     frame_count_q, frame_count_d;

    logic            vsync_rise;
    logic            last_col;
    logic            ovf_set, lerr_set, frame_done;
    logic            fifo_wr, fifo_full, fifo_empty;
    pix_tag_t        wr_tag, rd_tag;
    logic [WordWidth-1:0] fifo_wdata, fifo_rdata;

    assign vsync_rise = vid_vsync && !vsync_q;
    assign last_col   = (col_q == LastCol);

    // Capture FSM: frame arming, pixel/line counting and error detection
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        sof_d      = sof_q;
        ovf_set    = 1'b0;
        lerr_set   = 1'b0;
        frame_done = 1'b0;
        fifo_wr    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable && vsync_rise) begin
                    state_d = StArmed;
                    col_d   = '0;
                    row_d   = '0;
                    sof_d   = 1'b1;
                end
            end
            StArmed, StActive: begin
                if (vsync_rise) begin
                    // Early frame restart: re-arm without counting a completed frame
                    state_d = StArmed;
                    col_d   = '0;
                    row_d   = '0;
                    sof_d   = 1'b1;
                end else if (vid_de) begin
                    if (fifo_full) begin
                        ovf_set = 1'b1;
                        state_d = StDrop;
                    end else begin
                        fifo_wr = 1'b1;
                        sof_d   = 1'b0;
                        state_d = StActive;
                        if (last_col) begin
                            col_d = '0;
                            row_d = row_q + RW'(1);
                            if (row_q == LastRow) begin
                                frame_done = 1'b1;
                                state_d    = StIdle;
                            end
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end
                end else if (state_q == StActive && de_q && col_q != '0) begin
                    // DE dropped mid-line: abandon the partial line (it never gets TLAST)
                    lerr_set = 1'b1;
                    col_d    = '0;
                    row_d    = row_q + RW'(1);
                end
            end
            StDrop: begin
                if (vsync_rise) begin
                    state_d = enable ? StArmed : StIdle;
                    col_d   = '0;
                    row_d   = '0;
                    sof_d   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Sticky flags (set beats clear) and frame counter next state
    always_comb begin
        overflow_d    = (overflow_q && !err_clr) || ovf_set;
        line_err_d    = (line_err_q && !err_clr) || lerr_set;
        frame_count_d = frame_done ? frame_count_q + 16'd1 : frame_count_q;
    end

    // State and status registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= StIdle;
            vsync_q       <= 1'b0;
            de_q          <= 1'b0;
            col_q         <= '0;
            row_q         <= '0;
            sof_q         <= 1'b0;
            overflow_q    <= 1'b0;
            line_err_q    <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            vsync_q       <= vid_vsync;
            de_q          <= vid_de;
            col_q         <= col_d;
            row_q         <= row_d;
            sof_q         <= sof_d;
            overflow_q    <= overflow_d;
            line_err_q    <= line_err_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Pack FIFO write word and unpack the head word onto the stream
    always_comb begin
        wr_tag.tuser = sof_q;
        wr_tag.tlast = last_col;
        fifo_wdata   = {wr_tag, vid_data};
        {rd_tag, OUTPUT_STREAM_TDATA} = fifo_rdata;
    end

    axis_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WordWidth)
    ) u_fifo (
        .clk     (aclk),
        .rst_n   (aresetn),
        .wr_en   (fifo_wr),
        .wr_data (fifo_wdata),
        .full    (fifo_full),
        .rd_en   (OUTPUT_STREAM_TREADY),
        .rd_data (fifo_rdata),
        .empty   (fifo_empty)
    );

    assign OUTPUT_STREAM_TVALID = !fifo_empty;
    assign OUTPUT_STREAM_TUSER  = rd_tag.tuser;
    assign OUTPUT_STREAM_TLAST  = rd_tag.tlast;
    assign OUTPUT_STREAM_TKEEP  = '1;
    assign OUTPUT_STREAM_TSTRB  = '1;
    assign OUTPUT_STREAM_TID    = 1'b0;
    assign OUTPUT_STREAM_TDEST  = 1'b0;

    assign overflow    = overflow_q;
    assign line_err    = line_err_q;
    assign frame_count = frame_count_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_video_in_axis_framer.sv
// Directed bench for video_in_axis_framer on a reduced 8x4 image.
module tb_video_in_axis_framer;

    localparam int unsigned W  = 8;
    localparam int unsigned H  = 4;
    localparam int unsigned FD = 16;
    localparam int unsigned DW = 32;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          enable, err_clr, vid_vsync, vid_de;
    logic [DW-1:0] vid_data;
    logic          tvalid, tready, tuser, tlast, tid, tdest;
    logic [DW-1:0] tdata;
    logic [DW/8-1:0] tkeep, tstrb;
    logic          overflow, line_err, busy;
    logic [15:0]   frame_count;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    bit toggle   = 1'b0;
    int stab_err = 0;

    logic [33:0] got_q[$];
    logic [33:0] exp_q[$];

    always #5 aclk = ~aclk;

    video_in_axis_framer #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .FIFO_DEPTH (FD),
        .DATA_WIDTH (DW)
    ) dut (
        .aclk                 (aclk),
        .aresetn              (aresetn),
        .enable               (enable),
        .err_clr              (err_clr),
        .vid_vsync            (vid_vsync),
        .vid_de               (vid_de),
        .vid_data             (vid_data),
        .OUTPUT_STREAM_TVALID (tvalid),
        .OUTPUT_STREAM_TREADY (tready),
        .OUTPUT_STREAM_TDATA  (tdata),
        .OUTPUT_STREAM_TKEEP  (tkeep),
        .OUTPUT_STREAM_TSTRB  (tstrb),
        .OUTPUT_STREAM_TUSER  (tuser),
        .OUTPUT_STREAM_TLAST  (tlast),
        .OUTPUT_STREAM_TID    (tid),
        .OUTPUT_STREAM_TDEST  (tdest),
        .overflow             (overflow),
        .line_err             (line_err),
        .frame_count          (frame_count),
        .busy                 (busy)
    );

    // Beat capture and stall-stability monitor, sampled mid-cycle
    logic        prev_stall = 1'b0;
    logic [33:0] prev_word;
    always @(negedge aclk) begin
        if (!aresetn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!tvalid || {tuser, tlast, tdata} !== prev_word)) stab_err++;
            if (tvalid && tready) got_q.push_back({tuser, tlast, tdata});
            prev_stall = tvalid && !tready;
            prev_word  = {tuser, tlast, tdata};
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
        cyc++;
        if (toggle) tready = ((cyc / 3) % 2) == 0;
    endtask

    task automatic vsync_pulse();
        vid_vsync = 1'b1;
        tick();
        vid_vsync = 1'b0;
        tick();
    endtask

    // Drive one pixel for a cycle; queue the expected beat when it should be accepted
    task automatic pixel(input logic [31:0] d, input bit u, input bit l, input bit keep);
        vid_de   = 1'b1;
        vid_data = d;
        tick();
        vid_de   = 1'b0;
        if (keep) exp_q.push_back({u, l, d});
    endtask

    task automatic drain(input string tag);
        int i;
        for (i = 0; i < 200 && tvalid; i++) tick();
        check({tag, "_drain"}, tvalid, 1'b0);
    endtask

    task automatic compare_beats(input string tag);
        int n;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("%s_beat%0d", tag, i), got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 1'b0; enable = 1'b0; err_clr = 1'b0; vid_vsync = 1'b0;
        vid_de = 1'b0; vid_data = '0; tready = 1'b1;
        repeat (3) tick();
        aresetn = 1'b1;
        tick();

        // Reset state and constant sidebands
        check("rst_tvalid", tvalid, 0);
        check("rst_tdata", tdata, 0);
        check("rst_tuser_tlast", {tuser, tlast}, 0);
        check("rst_flags", {overflow, line_err, busy}, 0);
        check("rst_frame_count", frame_count, 0);
        check("const_keep_strb", {tkeep, tstrb}, 8'hFF);
        check("const_tid_tdest", {tid, tdest}, 0);

        // Full frame, TREADY high, data = row*W+col
        enable = 1'b1;
        vsync_pulse();
        check("armed_busy", busy, 1);
        pixel(0, 1, 0, 1);
        check("latency_first_beat", {tvalid, tuser, tlast, tdata}, {3'b110, 32'd0});
        for (int i = 1; i < W * H; i++) pixel(i, 0, (i % W) == W - 1, 1);
        check("f1_frame_count", frame_count, 1);
        check("f1_busy", busy, 0);
        drain("f1");
        compare_beats("f1");

        // Same frame with TREADY toggling every 3 cycles and 2-cycle DE gaps per line
        toggle = 1'b1;
        vsync_pulse();
        for (int i = 0; i < W * H; i++) begin
            pixel(i, i == 0, (i % W) == W - 1, 1);
            if ((i % W) == W - 1) begin tick(); tick(); end
        end
        drain("f2");
        toggle = 1'b0;
        tready = 1'b1;
        tick();
        compare_beats("f2");
        check("f2_overflow", overflow, 0);
        check("f2_line_err", line_err, 0);
        check("f2_frame_count", frame_count, 2);
        check("f2_stall_stable", stab_err, 0);

        // Overflow: TREADY low, 20 contiguous pixels into a 16-deep FIFO
        tready = 1'b0;
        vsync_pulse();
        vid_de = 1'b1;
        for (int i = 0; i < 20; i++) begin
            vid_data = 100 + i;
            tick();
            if (i < FD) exp_q.push_back({i == 0, (i % W) == W - 1, 32'(100 + i)});
            if (i == FD - 1) check("ovf_before_full", overflow, 0);
            if (i == FD) check("ovf_on_pixel17", {overflow, busy}, 2'b11);
        end
        vid_de = 1'b0;
        tick();
        check("ovf_head_held", {tvalid, tuser, tdata}, {2'b11, 32'd100});
        tready = 1'b1;
        drain("ovf");
        for (int i = 0; i < 4; i++) pixel(900 + i, 0, 0, 0);
        tick();
        compare_beats("ovf");
        check("ovf_sticky", overflow, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("ovf_cleared", overflow, 0);
        enable = 1'b0;
        vsync_pulse();
        check("drop_exit_idle", busy, 0);
        check("ovf_frame_count", frame_count, 2);

        // Short line: 3 pixels, DE low, then 3 full lines complete the frame
        enable = 1'b1;
        vsync_pulse();
        for (int i = 0; i < 3; i++) pixel(200 + i, i == 0, 0, 1);
        check("sl_no_err_yet", line_err, 0);
        tick();
        check("sl_line_err", line_err, 1);
        for (int j = 0; j < 3 * W; j++) pixel(203 + j, 0, (j % W) == W - 1, 1);
        check("sl_frame_done", {busy, frame_count}, {1'b0, 16'd3});
        drain("sl");
        compare_beats("sl");
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("sl_cleared", line_err, 0);

        // Early vsync after 2 lines restarts the frame without counting
        vsync_pulse();
        for (int i = 0; i < 2 * W; i++) pixel(300 + i, i == 0, (i % W) == W - 1, 1);
        tick();
        vsync_pulse();
        check("early_count_held", {busy, frame_count}, {1'b1, 16'd3});
        for (int i = 0; i < W * H; i++) pixel(400 + i, i == 0, (i % W) == W - 1, 1);
        check("early_frame_done", frame_count, 4);
        drain("early");
        compare_beats("early");
        check("early_line_err", line_err, 0);

        // enable low in IDLE: vsync pulses and pixels produce nothing
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            vsync_pulse();
            for (int i = 0; i < 5; i++) pixel(800 + i, 0, 0, 0);
        end
        tick();
        compare_beats("dis");
        check("dis_idle", {tvalid, busy}, 0);

        // Reset mid-frame with 8 words buffered
        enable = 1'b1;
        tready = 1'b0;
        vsync_pulse();
        for (int i = 0; i < 8; i++) pixel(600 + i, 0, 0, 0);
        check("rm_buffered", tvalid, 1);
        aresetn = 1'b0;
        #1;
        check("rm_tvalid_drop", {tvalid, tdata}, 0);
        check("rm_state", {busy, frame_count}, 0);
        tick();
        tick();
        aresetn = 1'b1;
        tick();
        tready = 1'b1;
        vsync_pulse();
        for (int i = 0; i < W * H; i++) pixel(700 + i, i == 0, (i % W) == W - 1, 1);
        drain("rm");
        compare_beats("rm");
        check("rm_frame_count", frame_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
